// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Build option STREAM_DEMUX_RR_EN selects round-robin routing.
package stream_demux_pkg;

   localparam int DROP_CNT_W = 8;

   typedef enum logic {
      BUF_EMPTY,
      BUF_FULL
   } buf_state_e;

   function automatic int next_ptr(input int ptr, input int n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/stream_buf_slot.sv
// One-entry output buffer: holds a single beat until its sink takes it.
// A load while full replaces the beat being drained in the same cycle.
module stream_buf_slot
   import stream_demux_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] dout
);

   buf_state_e st;

   assign valid = (st == BUF_FULL);

   // Occupancy FSM; payload only changes on load
   always_ff @(posedge clk) begin
      if (!rst) begin
         st   <= BUF_EMPTY;
         dout <= '0;
      end else begin
         unique case (st)
            BUF_EMPTY: begin
               if (load) begin
                  st   <= BUF_FULL;
                  dout <= din;
               end
            end
            BUF_FULL: begin
               if (load) begin
                  dout <= din;
               end else if (ready) begin
                  st <= BUF_EMPTY;
               end
            end
            default: st <= BUF_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready stream to N one-entry output channels.
// Define STREAM_DEMUX_RR_EN to route round-robin instead of by in_sel.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_data,
   input  logic [SW-1:0]         in_sel,
   output logic [N-1:0]          out_valid,
   input  logic [N-1:0]          out_ready,
   output logic [N*W-1:0]        out_data,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   logic [SW-1:0] dst;
   logic          in_range;
   logic          take;
   logic [N-1:0]  load;

`ifdef STREAM_DEMUX_RR_EN
   logic [SW-1:0] ptr;
   logic          unused_sel;

   assign unused_sel = ^in_sel;
   assign dst        = ptr;
   assign in_range   = 1'b1;

   // Pointer steps past each accepted beat, wrapping at N-1
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= '0;
      end else if (take) begin
         ptr <= SW'(next_ptr(int'(ptr), N));
      end
   end
`else
   assign dst      = in_sel;
   assign in_range = (int'(dst) < N);
`endif

   // Out-of-range beats are swallowed; in-range ones need room
   assign in_ready = in_range
                   ? (!out_valid[dst] || out_ready[dst])
                   : 1'b1;

   assign take = in_valid && in_ready;

   // Saturating count of beats addressed to no channel
   always_ff @(posedge clk) begin
      if (!rst) begin
         drop_cnt <= '0;
      end else if (in_valid && !in_range
                   && drop_cnt != '1) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_ch
      assign load[k] = take && in_range
                     && (int'(dst) == k);

      stream_buf_slot #(
         .W (W)
      ) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (load[k]),
         .din   (in_data),
         .valid (out_valid[k]),
         .ready (out_ready[k]),
         .dout  (out_data[k*W +: W])
      );
   end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Stream demultiplexer, the inverse of the selector mux: one valid/ready input stream is routed to one of N registered output channels.
- The input selector chooses the channel.
- Each output channel holds a one-entry buffer, so a stalled sink blocks only transfers addressed to it.
- Used wherever a shared stream fans out to per-consumer queues.

Parameters:
- W, 8, data width in bits.
- N, 4, number of output channels (2..16; need not be a power of two).
- SW, $clog2(N), selector width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid is also high.
- in_data  input  W  input payload.
- in_sel  input  SW  destination channel index.
- out_valid  output  N  per-channel beat held.
- out_ready  input  N  per-channel sink accepts.
- out_data  output  N*W  channel k payload in bits [k*W +: W].
- drop_cnt  output  8  saturating count of beats with out-of-range in_sel.

Behaviour:
- Reset (rst==0 at posedge):
  - out_valid = 0 and drop_cnt = 0.
  - out_data is held at 0.
  - Reset mid-transfer discards buffered beats with no output handshake.
- Transfer definitions:
  - Input transfer: in_valid && in_ready.
  - Output transfer k: out_valid[k] && out_ready[k].
- in_ready is combinational:
  - in_sel < N: in_ready = !out_valid[in_sel] || out_ready[in_sel]. Pass-through refill: a full buffer being drained accepts in the same cycle.
  - in_sel >= N: in_ready = 1; the beat is dropped and drop_cnt increments, saturating at 255.
  - in_ready does not depend on in_valid.
- Latency: a beat accepted at edge t appears at out_valid/out_data after edge t. One cycle, zero bubbles. Sustained throughput is 1 beat/cycle per channel when its sink is always ready.
- Per-channel buffer has two states, EMPTY and FULL:
  - EMPTY -> FULL on an input transfer with in_sel==k.
  - FULL -> EMPTY on output transfer k with no simultaneous input for k.
  - FULL -> FULL with new data on simultaneous output k and input for k.
- Only the addressed channel's state changes on an input transfer; other channels progress independently.
- out_data[k] is stable while out_valid[k] && !out_ready[k]. It changes only on load.
- in_data/in_sel may change freely while in_valid==0. The input side must hold them stable until transfer (standard valid/ready; not checked in RTL).
- No combinational path from in_valid to out_valid.

Optional Feature:
- Macro: STREAM_DEMUX_RR_EN.
- Defined:
  - in_sel is ignored.
  - An internal SW-bit pointer picks the destination. It resets to 0 and advances by 1 modulo N after each input transfer, so wrap at N-1 -> 0 even for non-power-of-two N.
  - in_ready uses the pointer channel.
  - The out-of-range drop path is unreachable and drop_cnt stays 0.
- Not defined: in_sel routing as above, no pointer register.

Decomposition:
- Package stream_demux_pkg:
  - localparam DROP_CNT_W = 8.
  - enum typedef buf_state_e {BUF_EMPTY, BUF_FULL}.
  - Helper function next_ptr(ptr, n) implementing wrap modulo n.
- Sub-module stream_buf_slot:
  - One-entry buffer with load, data in, valid/ready out.
  - W parameter, same clk/rst.
  - Instantiated N times by a generate loop in stream_demux.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, drop_cnt=0, no state change. After release, out_ready all 1, send in_sel=2, data 0xA5 -> out_valid=4'b0100, out_data[2]=0xA5 one cycle later.
- Backpressure: out_ready[1]=0, send 0x11 then 0x22 to ch1:
  - Second beat sees in_ready=0 and out_data[1] holds 0x11.
  - Raise out_ready[1] -> same-cycle accept of 0x22, and out_valid[1] stays 1 with 0x22 next cycle.
- Independence: ch0 stalled full. Beats to ch3 stream back-to-back 0x30..0x37 -> all accepted at 1/cycle, ch0 untouched.
- Out-of-range: N=3, in_sel=3 for 300 beats -> in_ready=1 every cycle, no out_valid, drop_cnt saturates at 255.
- Simultaneous drain+fill on all channels: random data, all out_ready=1 -> scoreboard shows in-order delivery per channel with zero loss or duplication.
- With STREAM_DEMUX_RR_EN, N=3: 7 beats 0..6 with in_sel=X -> channels 0,1,2,0,1,2,0. Stalling ch1 holds the pointer at 1 until it drains.
